// File: rtl/diagonal_expand.sv
// diagonal_expand
//
// Purpose: takes the SIZE diagonal elements of a matrix as a valid/ready
// stream (index 0 first). It then emits the dense SIZE x SIZE diagonal
// matrix in row-major order. Diagonal positions carry the loaded values and
// every other position carries zero. Loading and emitting never overlap.
//
// Parameters:
//   SIZE        matrix dimension (>= 2)
//   DATA_WIDTH  element width in bits
//
// Ports:
//   clk         clock, all logic on the rising edge
//   rst         asynchronous, active-low reset
//   in_tdata    diagonal element
//   in_tvalid   in_tdata valid
//   in_tready   block can accept an element (high only while loading)
//   out_tdata   matrix element, row-major
//   out_tready  downstream can accept
//   out_tvalid  out_tdata valid (high only while emitting)
//   out_tlast   last element of the matrix (only with DIAG_EXPAND_TLAST_EN)
//
// Optional feature: define DIAG_EXPAND_TLAST_EN to add the out_tlast port.

module diagonal_expand #(
  parameter int SIZE       = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  output logic [DATA_WIDTH-1:0] out_tdata,
  input  logic                  out_tready,
  output logic                  out_tvalid
`ifdef DIAG_EXPAND_TLAST_EN
  ,
  output logic                  out_tlast
`endif
);

  localparam int CW = (SIZE > 2) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EMIT
  } state_t;

  state_t state;
  state_t next_state;

  logic [CW-1:0]         in_cnt;
  logic [CW-1:0]         row;
  logic [CW-1:0]         col;
  logic [DATA_WIDTH-1:0] diag [SIZE];

  logic in_fire;
  logic out_fire;
  logic at_last_elem;

  // The handshakes are decoded straight from the state so that in_tready
  // never depends combinationally on out_tready.
  assign in_fire      = (state == S_LOAD) && in_tvalid;
  assign out_fire     = (state == S_EMIT) && out_tready;
  assign at_last_elem = (row == LAST_IDX) && (col == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode. The output element is a mux of registers
  // only. row/col/diag are frozen while stalled, so out_tdata holds steady.
  always_comb begin
    next_state = state;
    in_tready  = 1'b0;
    out_tvalid = 1'b0;
    out_tdata  = '0;
    case (state)
      S_IDLE: begin
        next_state = S_LOAD;
      end
      S_LOAD: begin
        in_tready = 1'b1;
        if (in_tvalid && (in_cnt == LAST_IDX)) begin
          next_state = S_EMIT;
        end
      end
      S_EMIT: begin
        out_tvalid = 1'b1;
        if (row == col) begin
          out_tdata = diag[row];
        end
        if (out_tready && at_last_elem) begin
          next_state = S_LOAD;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Load counter, diagonal buffer and emit position. Each counter wraps to 0
  // on its last index, so none of them ever exceeds SIZE-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt <= '0;
      row    <= '0;
      col    <= '0;
      for (int i = 0; i < SIZE; i++) begin
        diag[i] <= '0;
      end
    end else begin
      if (in_fire) begin
        diag[in_cnt] <= in_tdata;
        if (in_cnt == LAST_IDX) begin
          in_cnt <= '0;
          row    <= '0;
          col    <= '0;
        end else begin
          in_cnt <= in_cnt + 1'b1;
        end
      end
      if (out_fire) begin
        if (col == LAST_IDX) begin
          col <= '0;
          if (row == LAST_IDX) begin
            row <= '0;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

`ifdef DIAG_EXPAND_TLAST_EN
  assign out_tlast = (state == S_EMIT) && at_last_elem;
`endif

endmodule

// File: tb/tb_diagonal_expand.sv
// tb_diagonal_expand
//
// Scoreboard bench for diagonal_expand (SIZE=4, DATA_WIDTH=32). Stimulus
// tasks push the expected matrix elements into a queue when a load is issued.
// A monitor pops and compares on every output transfer. The monitor also
// checks that in_tready stays low during emission and that out_tdata holds
// steady while stalled.

module tb_diagonal_expand;

  localparam int SIZE = 4;
  localparam int DW   = 32;
  localparam int TIMEOUT = 300;

  logic          clk_tb = 1'b0;
  logic          rst;
  logic [DW-1:0] in_tdata;
  logic          in_tvalid;
  logic          in_tready;
  logic [DW-1:0] out_tdata;
  logic          out_tready;
  logic          out_tvalid;
`ifdef DIAG_EXPAND_TLAST_EN
  logic          out_tlast;
`endif

  always #5 clk_tb = ~clk_tb;

  diagonal_expand #(
    .SIZE       (SIZE),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk_tb),
    .rst        (rst),
    .in_tdata   (in_tdata),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .out_tdata  (out_tdata),
    .out_tready (out_tready),
    .out_tvalid (out_tvalid)
`ifdef DIAG_EXPAND_TLAST_EN
    ,
    .out_tlast  (out_tlast)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          sb_q[$];
  int            checks    = 0;
  int            errors    = 0;
  int            out_count = 0;
  logic          bp_mode   = 1'b0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;

  // Hand-computed dense matrix for the diagonal 0x11,0x22,0x33,0x44.
  logic [DW-1:0] basic_exp [16] = '{
    32'h11, 32'h00, 32'h00, 32'h00,
    32'h00, 32'h22, 32'h00, 32'h00,
    32'h00, 32'h00, 32'h33, 32'h00,
    32'h00, 32'h00, 32'h00, 32'h44
  };

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out after %0d cycles", name, TIMEOUT);
  endtask

  // Expected dense matrix for a diagonal. d[0] is the first-loaded element.
  task automatic pushModel(input logic [SIZE-1:0][DW-1:0] d);
    exp_t e;
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        e.data = (r == c) ? d[r] : '0;
        e.last = (r == SIZE - 1) && (c == SIZE - 1);
        sb_q.push_back(e);
      end
    end
  endtask

  // Present one element and hold it until accepted. Inputs change only at
  // posedge+1, so the in_tready level seen at negedge decides the next edge.
  task automatic sendElem(input logic [DW-1:0] v);
    int n;
    in_tdata  = v;
    in_tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk_tb);
      if (in_tready) break;
      n++;
      if (n > TIMEOUT) begin
        timeoutFail("in_handshake");
        in_tvalid = 1'b0;
        return;
      end
    end
    @(posedge clk_tb);
    #1;
    in_tvalid = 1'b0;
  endtask

  // Load a full diagonal, optionally with one idle cycle between elements.
  task automatic applyStimulus(input logic [SIZE-1:0][DW-1:0] d, input bit gap);
    for (int i = 0; i < SIZE; i++) begin
      sendElem(d[i]);
      if (gap && (i < SIZE - 1)) begin
        @(posedge clk_tb);
        #1;
      end
    end
    checkOutput("out_tvalid_after_load", {63'd0, out_tvalid}, 64'd1);
  endtask

  // Wait until every expected element was seen, then expect loading again.
  task automatic waitDrain(input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk_tb);
      #1;
      if (sb_q.size() == 0) break;
      n++;
      if (n > TIMEOUT) begin
        timeoutFail(name);
        return;
      end
    end
    @(posedge clk_tb);
    #1;
    checkOutput({name, "_in_tready_back"}, {63'd0, in_tready}, 64'd1);
    checkOutput({name, "_out_tvalid_low"}, {63'd0, out_tvalid}, 64'd0);
  endtask

  // Toggle out_tready every cycle while back-pressure mode is on.
  always @(posedge clk_tb) begin
    if (bp_mode) begin
      #1;
      out_tready = ~out_tready;
    end
  end

  // Monitor: compare every output transfer against the scoreboard.
  always @(negedge clk_tb) begin
    exp_t e;
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (out_tvalid) begin
        checkOutput("in_tready_low_in_emit", {63'd0, in_tready}, 64'd0);
      end
      if (stall_prev && out_tvalid) begin
        checkOutput("stall_hold_tdata", {32'd0, out_tdata}, {32'd0, stall_data});
      end
      if (out_tvalid && out_tready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got 0x%0h, expected no transfer",
                   out_tdata);
        end else begin
          e = sb_q.pop_front();
          checkOutput("out_tdata", {32'd0, out_tdata}, {32'd0, e.data});
`ifdef DIAG_EXPAND_TLAST_EN
          checkOutput("out_tlast", {63'd0, out_tlast}, {63'd0, e.last});
`endif
          out_count++;
        end
      end
      stall_prev = out_tvalid && !out_tready;
      stall_data = out_tdata;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    int   base;
    int   n;

    rst        = 1'b0;
    in_tdata   = '0;
    in_tvalid  = 1'b0;
    out_tready = 1'b1;

    // Reset values, including across a clock edge while held in reset.
    #12;
    checkOutput("reset_out_tvalid", {63'd0, out_tvalid}, 64'd0);
    checkOutput("reset_in_tready", {63'd0, in_tready}, 64'd0);
    checkOutput("reset_out_tdata", {32'd0, out_tdata}, 64'd0);
    @(posedge clk_tb);
    #1;
    checkOutput("reset_hold_in_tready", {63'd0, in_tready}, 64'd0);
    @(negedge clk_tb);
    rst = 1'b1;
    #1;
    checkOutput("release_in_tready_before_edge", {63'd0, in_tready}, 64'd0);
    @(posedge clk_tb);
    #1;
    checkOutput("release_in_tready_after_edge", {63'd0, in_tready}, 64'd1);

    // Basic expansion: explicit table, 16 consecutive outputs.
    $display("[TB] basic expansion");
    for (int i = 0; i < 16; i++) begin
      e.data = basic_exp[i];
      e.last = (i == 15);
      sb_q.push_back(e);
    end
    applyStimulus({32'h44, 32'h33, 32'h22, 32'h11}, 1'b0);
    for (int i = 0; i < SIZE * SIZE; i++) begin
      @(negedge clk_tb);
      checkOutput("basic_consecutive_valid", {63'd0, out_tvalid}, 64'd1);
    end
    @(posedge clk_tb);
    #1;
    checkOutput("basic_in_tready_back", {63'd0, in_tready}, 64'd1);
    checkOutput("basic_out_tvalid_low", {63'd0, out_tvalid}, 64'd0);
    checkOutput("basic_all_consumed", 64'(sb_q.size()), 64'd0);

    // Input gaps.
    $display("[TB] input gaps");
    pushModel({32'd4, 32'd3, 32'd2, 32'd1});
    applyStimulus({32'd4, 32'd3, 32'd2, 32'd1}, 1'b1);
    waitDrain("gaps");

    // Back-pressure with stray in_tvalid pulses during emission.
    $display("[TB] back-pressure");
    pushModel({32'd8, 32'd7, 32'd6, 32'd5});
    applyStimulus({32'd8, 32'd7, 32'd6, 32'd5}, 1'b0);
    bp_mode = 1'b1;
    in_tdata = 32'hEE;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_tb);
      #1;
      in_tvalid = ~in_tvalid;
    end
    in_tvalid = 1'b0;
    waitDrain("backpressure");
    bp_mode = 1'b0;
    @(posedge clk_tb);
    #2;
    out_tready = 1'b1;

    // Back-to-back matrices; the second diagonal waits for in_tready.
    $display("[TB] back-to-back");
    pushModel({32'd4, 32'd3, 32'd2, 32'd1});
    pushModel({32'hD, 32'hC, 32'hB, 32'hA});
    applyStimulus({32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
    applyStimulus({32'hD, 32'hC, 32'hB, 32'hA}, 1'b0);
    waitDrain("back_to_back");

    // Reset after the 6th output transfer.
    $display("[TB] reset mid-emit");
    base = out_count;
    pushModel({32'd4, 32'd3, 32'd2, 32'd1});
    applyStimulus({32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
    n = 0;
    forever begin
      @(negedge clk_tb);
      #1;
      if (out_count >= base + 6) break;
      n++;
      if (n > TIMEOUT) begin
        timeoutFail("reset_wait_6th");
        break;
      end
    end
    @(posedge clk_tb);
    #1;
    rst = 1'b0;
    sb_q.delete();
    #1;
    checkOutput("midreset_out_tvalid", {63'd0, out_tvalid}, 64'd0);
    checkOutput("midreset_in_tready", {63'd0, in_tready}, 64'd0);
    checkOutput("midreset_out_tdata", {32'd0, out_tdata}, 64'd0);
    checkOutput("midreset_transfer_count", 64'(out_count - base), 64'd6);
    @(negedge clk_tb);
    rst = 1'b1;
    #1;
    checkOutput("midreset_release_before_edge", {63'd0, in_tready}, 64'd0);
    @(posedge clk_tb);
    #1;
    checkOutput("midreset_release_after_edge", {63'd0, in_tready}, 64'd1);
    pushModel({32'd9, 32'd9, 32'd9, 32'd9});
    applyStimulus({32'd9, 32'd9, 32'd9, 32'd9}, 1'b0);
    waitDrain("after_reset");

    repeat (3) @(posedge clk_tb);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/diagonal_expand.md
Name: diagonal_expand

Overview:
- Inverse of diagonal_matrix: accepts the SIZE diagonal elements of a matrix as a stream.
- Emits the full SIZE x SIZE diagonal matrix row-major on an output stream: diagonal values in place, zeros elsewhere.
- Sits downstream of matrix ops that produce diagonal vectors, feeding consumers that expect dense matrices.
- Uses the same valid/ready stream interface as the rest of the matrix IP.

Parameters:
SIZE, 4, matrix dimension; SIZE >= 2
DATA_WIDTH, 32, element width in bits

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-low
in_tdata  input  DATA_WIDTH  diagonal element, index 0 first
in_tvalid  input  1  in_tdata valid
in_tready  output  1  block can accept an element
out_tdata  output  DATA_WIDTH  matrix element, row-major
out_tready  input  1  downstream can accept
out_tvalid  output  1  out_tdata valid

Behaviour:
- Interface: one clock (clk); rst is asynchronous and active-low. While rst=0: state=S_IDLE, all counters 0, diag buffer cleared to 0, out_tvalid=0, out_tdata=0, in_tready=0.
- Handshake: a transfer occurs on a rising edge where tvalid&&tready. The producer holds tvalid/tdata until the transfer.
- in_tready = (state==S_LOAD); it is a registered-state decode with no combinational path from out_tready.
- S_IDLE: go to S_LOAD on the next edge unconditionally, so in_tready rises on the first edge after rst releases.
- S_LOAD:
  - Each input transfer writes diag[in_cnt] <= in_tdata, then in_cnt++.
  - On the transfer with in_cnt==SIZE-1: in_cnt<=0, row<=0, col<=0, state<=S_EMIT.
  - in_tvalid gaps stall loading and do not lose data.
- S_EMIT:
  - out_tvalid=1.
  - out_tdata = (row==col) ? diag[row] : 0. It is driven only from registers and stays stable while out_tvalid && !out_tready.
  - On each output transfer, col++. When col==SIZE-1: col<=0, row++.
  - On the transfer with row==col==SIZE-1: state<=S_LOAD and out_tvalid drops the next cycle.
- Latency:
  - out_tvalid rises 1 cycle after the last input transfer.
  - in_tready rises 1 cycle after the last output transfer.
  - With out_tready held at 1, emission takes exactly SIZE*SIZE cycles.
- No overlap: in_tready=0 throughout S_EMIT, and in_tvalid is ignored there.
- out_tready low in S_EMIT freezes row, col and out_tdata; no element is skipped or duplicated.
- Counter widths are $clog2(SIZE), minimum 1. Counters never exceed SIZE-1 and wrap only as specified.
- Reset mid-operation: any state returns to the reset values immediately. A partially loaded or emitted matrix is discarded.
- out_tvalid and out_tdata = 0 whenever state != S_EMIT.

Optional Feature:
- Macro: DIAG_EXPAND_TLAST_EN.
- Defined:
  - Adds output port out_tlast (1 bit).
  - out_tlast=1 exactly when out_tvalid=1, row==SIZE-1 and col==SIZE-1; otherwise 0.
  - out_tlast resets to 0 and holds under back-pressure like out_tdata.
- Undefined: the port does not exist, and the behaviour is otherwise identical.

Test Plan:
- Basic expansion (SIZE=4, out_tready=1): send 0x11,0x22,0x33,0x44 -> 16 outputs 0x11,0,0,0, 0,0x22,0,0, 0,0,0x33,0, 0,0,0,0x44 on consecutive cycles; out_tvalid rises 1 cycle after the 0x44 transfer; in_tready returns 1 cycle after the 16th output.
- Input gaps: in_tvalid toggled 1/0 every cycle with values 1,2,3,4 -> output identical to an ungapped load of 1,2,3,4; no extra or missing elements.
- Back-pressure: out_tready toggled every cycle, diag 5,6,7,8 -> 16 transfers in 32 cycles; out_tdata constant while stalled; in_tready=0 throughout; in_tvalid pulses during S_EMIT are not captured.
- Back-to-back: load A=1..4, then B=0xA..0xD presented as soon as in_tready rises -> 32 outputs, second matrix diagonal 0xA,0xB,0xC,0xD; no leakage of A values.
- Reset mid-emit: assert rst after the 6th output transfer -> out_tvalid=0 and in_tready=0 immediately; after release, in_tready=1 on the next edge; a new load of 9,9,9,9 yields a clean 16-element matrix.
- DIAG_EXPAND_TLAST_EN, SIZE=6: out_tlast high only on the 36th transfer (value = diag[5]), held through a 3-cycle out_tready stall.
